// File: rtl/bus_write_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bus_write_arbiter_pkg
// Brief    : Shared constants and beat/address types for the write-bus arbiter.
// Revision : 1.0
// ============================================================================
package bus_write_arbiter_pkg;

    localparam int CORE_NUMBER     = 8;
    localparam int BUS_ARRAY_WIDTH = 6;
    localparam int NUMBER_WIDTH    = 32;
    localparam int SLAVE_ADDR      = 6;
    localparam int MAX_BURST_LEN   = 16;
    localparam int CORE_ID_W       = $clog2(CORE_NUMBER);
    localparam int MASTER_ADDR     = SLAVE_ADDR + CORE_ID_W;

    typedef logic [NUMBER_WIDTH-1:0] number_t;
    typedef number_t [BUS_ARRAY_WIDTH-1:0] bus_beat_t;

    typedef struct packed {
        logic [CORE_ID_W-1:0]  core_id;
        logic [SLAVE_ADDR-1:0] slave_addr;
    } master_addr_t;

endpackage
`default_nettype wire

// File: rtl/bus_write_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : bus_write_arbiter_if
// Brief    : Per-core write request bundle plus the shared downstream port.
// Revision : 1.0
// ============================================================================
interface bus_write_arbiter_if
    import bus_write_arbiter_pkg::*;
#(
    parameter int NUM_CORES = CORE_NUMBER,
    parameter int LANES     = BUS_ARRAY_WIDTH,
    parameter int DATA_W    = NUMBER_WIDTH,
    parameter int SADDR_W   = SLAVE_ADDR
);
    localparam int BEAT_W  = LANES * DATA_W;
    localparam int MADDR_W = SADDR_W + $clog2(NUM_CORES);

    logic [NUM_CORES-1:0]         s_wvalid;
    logic [NUM_CORES-1:0]         s_wready;
    logic [NUM_CORES*BEAT_W-1:0]  s_wdata;
    logic [NUM_CORES*SADDR_W-1:0] s_waddr;
    logic [NUM_CORES-1:0]         s_wlast;
    logic                         m_wvalid;
    logic                         m_wready;
    logic [BEAT_W-1:0]            m_wdata;
    logic [MADDR_W-1:0]           m_waddr;
    logic                         m_wlast;
    logic                         err_overlong;

    // Arbiter side
    modport slave (
        input  s_wvalid, s_wdata, s_waddr, s_wlast, m_wready,
        output s_wready, m_wvalid, m_wdata, m_waddr, m_wlast, err_overlong
    );

    // Cores plus downstream sink side
    modport master (
        output s_wvalid, s_wdata, s_waddr, s_wlast, m_wready,
        input  s_wready, m_wvalid, m_wdata, m_waddr, m_wlast, err_overlong
    );

endinterface
`default_nettype wire

// File: rtl/bus_write_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Brief    : Combinational finder of the first set request bit at or after ptr.
// Revision : 1.0
// ============================================================================
module rr_pick #(
    parameter int N  = 8,
    parameter int PW = $clog2(N)
) (
    input  wire logic [N-1:0]  i_req,
    input  wire logic [PW-1:0] i_ptr,
    output logic               o_found,
    output logic [PW-1:0]      o_idx
);

    logic          w_found;
    logic [PW-1:0] w_idx;

    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        for (int i = 0; i < N; i++) begin
            if (!w_found && i_req[(int'(i_ptr) + i) % N]) begin
                w_found = 1'b1;
                w_idx   = PW'((int'(i_ptr) + i) % N);
            end
        end
    end

    assign o_found = w_found;
    assign o_idx   = w_idx;

endmodule
`default_nettype wire

// File: rtl/bus_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bus_write_arbiter
// Brief    : Round-robin, burst-locked arbiter sharing one write bus among cores.
// Revision : 1.0
// ============================================================================
module bus_write_arbiter
    import bus_write_arbiter_pkg::*;
#(
    parameter int NUM_CORES = CORE_NUMBER,
    parameter int LANES     = BUS_ARRAY_WIDTH,
    parameter int DATA_W    = NUMBER_WIDTH,
    parameter int SADDR_W   = SLAVE_ADDR,
    parameter int MAX_BURST = MAX_BURST_LEN
) (
    input wire logic          clk,
    input wire logic          rst_n,
    bus_write_arbiter_if.slave bus
);

    localparam int CW      = $clog2(NUM_CORES);
    localparam int BEAT_W  = LANES * DATA_W;
    localparam int MADDR_W = SADDR_W + CW;
    localparam int CNT_W   = $clog2(MAX_BURST);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t               r_state;
    logic [CW-1:0]        r_gnt;
    logic [CW-1:0]        r_rr_ptr;
    logic [CNT_W-1:0]     r_burst_cnt;
    logic [SADDR_W-1:0]   r_saddr;
    logic                 r_m_wvalid;
    logic [BEAT_W-1:0]    r_m_wdata;
    logic [MADDR_W-1:0]   r_m_waddr;
    logic                 r_m_wlast;
    logic                 r_err;

    logic                 w_found;
    logic [CW-1:0]        w_pick;
    logic                 w_room;
    logic                 w_accept;
    logic                 w_cut;
    logic                 w_end;
    logic [NUM_CORES-1:0] w_s_wready;

    rr_pick #(
        .N  (NUM_CORES),
        .PW (CW)
    ) u_rr_pick (
        .i_req   (bus.s_wvalid),
        .i_ptr   (r_rr_ptr),
        .o_found (w_found),
        .o_idx   (w_pick)
    );

    // The output register can take a beat when empty or draining this cycle.
    assign w_room   = !r_m_wvalid || bus.m_wready;
    assign w_accept = (r_state == BUSY) && bus.s_wvalid[r_gnt] && w_room;
    assign w_cut    = (r_burst_cnt == CNT_W'(MAX_BURST - 1));
    assign w_end    = bus.s_wlast[r_gnt] || w_cut;

    always_comb begin
        w_s_wready = '0;
        if (r_state == BUSY) begin
            w_s_wready[r_gnt] = w_room;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_gnt       <= '0;
            r_rr_ptr    <= '0;
            r_burst_cnt <= '0;
            r_saddr     <= '0;
            r_m_wvalid  <= 1'b0;
            r_m_wdata   <= '0;
            r_m_waddr   <= '0;
            r_m_wlast   <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            if (w_accept) begin
                r_m_wvalid <= 1'b1;
                r_m_wdata  <= bus.s_wdata[int'(r_gnt)*BEAT_W +: BEAT_W];
                r_m_waddr  <= {r_gnt, r_saddr};
                r_m_wlast  <= w_end;
            end else if (bus.m_wready) begin
                r_m_wvalid <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_gnt    <= w_pick;
                        r_saddr  <= bus.s_waddr[int'(w_pick)*SADDR_W +: SADDR_W];
                        r_rr_ptr <= (w_pick == CW'(NUM_CORES - 1)) ? '0 : w_pick + 1'b1;
                        r_state  <= BUSY;
                    end
                end
                BUSY: begin
                    if (w_accept) begin
                        if (w_end) begin
                            r_state     <= IDLE;
                            r_burst_cnt <= '0;
                            // A forced cut leaves the core's tail for a later grant.
                            if (!bus.s_wlast[r_gnt]) begin
                                r_err <= 1'b1;
                            end
                        end else begin
                            r_burst_cnt <= r_burst_cnt + 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.s_wready     = w_s_wready;
    assign bus.m_wvalid     = r_m_wvalid;
    assign bus.m_wdata      = r_m_wdata;
    assign bus.m_waddr      = r_m_waddr;
    assign bus.m_wlast      = r_m_wlast;
    assign bus.err_overlong = r_err;

endmodule
`default_nettype wire

// File: tb/tb_bus_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_write_arbiter
// Brief    : Scoreboard bench: per-core burst model, lock, order and timing checks.
// Revision : 1.0
// ============================================================================
module tb_bus_write_arbiter;
    import bus_write_arbiter_pkg::*;

    localparam int NC     = CORE_NUMBER;
    localparam int CW     = CORE_ID_W;
    localparam int BEAT_W = BUS_ARRAY_WIDTH * NUMBER_WIDTH;
    localparam int SW     = SLAVE_ADDR;
    localparam int MW     = MASTER_ADDR;
    localparam int MAXB   = MAX_BURST_LEN;

    logic clk;
    logic rst_n;

    bus_write_arbiter_if bus ();

    bus_write_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        bus_beat_t       data;
        logic [SW-1:0]   addr;
        logic            last;
    } drv_beat_t;

    typedef struct packed {
        bus_beat_t    data;
        master_addr_t maddr;
        logic         last;
    } exp_beat_t;

    drv_beat_t     drv_q [NC][$];
    exp_beat_t     exp_q [NC][$];
    int            seg_pos [NC];
    logic [SW-1:0] seg_addr [NC];
    int            rise_cyc [NC];
    bit            err_exp;
    int            checks;
    int            errors;
    int            cyc;
    int            gap_pct;
    int            bp_mode;
    int            bp_q [$];
    int            glog_core [$];
    int            glog_start [$];
    int            glog_end [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input bit ok, input string name,
                         input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: a core's stream is cut into arbiter bursts at its own
    // last flag or after MAXB beats; every beat of a burst carries the
    // address the core presented with that burst's first beat.
    task automatic push_beat(input int c, input bus_beat_t d,
                             input logic [SW-1:0] a, input logic l);
        drv_beat_t b;
        exp_beat_t e;
        b.data = d; b.addr = a; b.last = l;
        drv_q[c].push_back(b);
        if (seg_pos[c] == 0) seg_addr[c] = a;
        e.data             = d;
        e.maddr.core_id    = CW'(c);
        e.maddr.slave_addr = seg_addr[c];
        e.last             = l || (seg_pos[c] == MAXB - 1);
        if (!l && seg_pos[c] == MAXB - 1) err_exp = 1'b1;
        seg_pos[c] = e.last ? 0 : seg_pos[c] + 1;
        exp_q[c].push_back(e);
    endtask

    function automatic bus_beat_t rand_beat();
        bus_beat_t d;
        for (int i = 0; i < BUS_ARRAY_WIDTH; i++) d[i] = $urandom;
        return d;
    endfunction

    task automatic push_burst(input int c, input int len, input logic [SW-1:0] a);
        for (int k = 0; k < len; k++) push_beat(c, rand_beat(), a, k == len - 1);
    endtask

    task automatic flush_model();
        for (int c = 0; c < NC; c++) begin
            drv_q[c].delete();
            exp_q[c].delete();
            seg_pos[c] = 0;
        end
        err_exp = 1'b0;
    endtask

    task automatic clear_logs();
        glog_core.delete();
        glog_start.delete();
        glog_end.delete();
    endtask

    function automatic bit pending();
        for (int c = 0; c < NC; c++)
            if (drv_q[c].size() != 0 || exp_q[c].size() != 0) return 1'b1;
        return bus.m_wvalid;
    endfunction

    task automatic drain(input int budget, input string name);
        int n;
        bit busy;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            busy = pending();
        end while (busy && n < budget);
        check(!busy, name, n, budget);
        repeat (3) @(negedge clk);
    endtask

    // Core and downstream driver
    initial begin
        logic [NC-1:0] acc;
        bit            v;
        bus.s_wvalid = '0;
        bus.s_wdata  = '0;
        bus.s_waddr  = '0;
        bus.s_wlast  = '0;
        bus.m_wready = 1'b1;
        forever begin
            @(negedge clk);
            acc = bus.s_wvalid & bus.s_wready;
            @(posedge clk);
            #1;
            if (!rst_n) acc = '0;
            for (int c = 0; c < NC; c++) begin
                if (acc[c] && drv_q[c].size() > 0) void'(drv_q[c].pop_front());
                if (drv_q[c].size() > 0) begin
                    v = ($urandom_range(99) >= gap_pct);
                    if (v && !bus.s_wvalid[c]) rise_cyc[c] = cyc;
                    bus.s_wvalid[c]              = v;
                    bus.s_wdata[c*BEAT_W +: BEAT_W] = drv_q[c][0].data;
                    bus.s_waddr[c*SW +: SW]      = drv_q[c][0].addr;
                    bus.s_wlast[c]               = drv_q[c][0].last;
                end else begin
                    bus.s_wvalid[c] = 1'b0;
                    bus.s_wlast[c]  = 1'b0;
                end
            end
            case (bp_mode)
                1:       bus.m_wready = 1'($urandom_range(1));
                2:       bus.m_wready = 1'b0;
                default: bus.m_wready = 1'b1;
            endcase
            if (bp_q.size() > 0) bus.m_wready = 1'(bp_q.pop_front());
        end
    end

    // Output monitor and scoreboard
    initial begin
        bit              prev_stall;
        bit              in_burst;
        int              cur;
        int              core;
        logic [BEAT_W-1:0] h_data;
        logic [MW-1:0]   h_addr;
        logic            h_last;
        exp_beat_t       e;
        prev_stall = 1'b0;
        in_burst   = 1'b0;
        cur        = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
                in_burst   = 1'b0;
            end else begin
                if (prev_stall)
                    check(bus.m_wvalid && bus.m_wdata == h_data && bus.m_waddr == h_addr
                          && bus.m_wlast == h_last, "hold_stable",
                          {bus.m_wdata, bus.m_wvalid, bus.m_wlast, bus.m_waddr},
                          {h_data, 1'b1, h_last, h_addr});
                prev_stall = bus.m_wvalid && !bus.m_wready;
                if (prev_stall) begin
                    h_data = bus.m_wdata;
                    h_addr = bus.m_waddr;
                    h_last = bus.m_wlast;
                    check(bus.s_wready == '0, "stall_ready", bus.s_wready, 0);
                end
                if (bus.m_wvalid && bus.m_wready) begin
                    core = int'(bus.m_waddr[MW-1 -: CW]);
                    if (in_burst) begin
                        check(core == cur, "burst_lock", core, cur);
                    end else begin
                        glog_core.push_back(core);
                        glog_start.push_back(cyc);
                    end
                    if (exp_q[core].size() == 0) begin
                        check(1'b0, "unexpected_beat", bus.m_waddr, 0);
                    end else begin
                        e = exp_q[core].pop_front();
                        check(bus.m_wdata == e.data && bus.m_waddr == e.maddr
                              && bus.m_wlast == e.last, "beat",
                              {bus.m_wdata, bus.m_wlast, bus.m_waddr},
                              {e.data, e.last, e.maddr});
                    end
                    if (bus.m_wlast) begin
                        in_burst = 1'b0;
                        glog_end.push_back(cyc);
                    end else begin
                        in_burst = 1'b1;
                        cur      = core;
                    end
                end
            end
        end
    end

    initial begin
        int exp_order [6];
        exp_order = '{0, 2, 7, 0, 2, 7};
        checks  = 0;
        errors  = 0;
        gap_pct = 0;
        bp_mode = 0;
        flush_model();
        clear_logs();

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check(bus.m_wvalid == 1'b0, "rst_m_wvalid", bus.m_wvalid, 0);
        check(bus.s_wready == '0, "rst_s_wready", bus.s_wready, 0);
        check(bus.err_overlong == 1'b0, "rst_err", bus.err_overlong, 0);
        check(bus.m_wdata == '0 && bus.m_waddr == '0 && bus.m_wlast == 1'b0, "rst_m_out",
              {bus.m_wdata, bus.m_wlast, bus.m_waddr}, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single core, 4 beats: out in cycles start+2 .. start+5, tag {3,5}
        clear_logs();
        push_burst(3, 4, 6'h05);
        drain(200, "drain_single");
        if (glog_core.size() == 1 && glog_end.size() == 1) begin
            check(glog_core[0] == 3, "single_grant", glog_core[0], 3);
            check(glog_start[0] - rise_cyc[3] == 2, "single_latency",
                  glog_start[0] - rise_cyc[3], 2);
            check(glog_end[0] - glog_start[0] == 3, "single_contig",
                  glog_end[0] - glog_start[0], 3);
        end else begin
            check(1'b0, "single_bursts", glog_core.size(), 1);
        end

        // Backpressure 1,0,0,1 on a 3-beat burst
        clear_logs();
        bp_q = '{1, 0, 0, 1};
        push_burst(6, 3, 6'h2C);
        drain(200, "drain_bp");
        if (glog_core.size() == 1 && glog_end.size() == 1) begin
            check(glog_start[0] - rise_cyc[6] == 3, "bp_first_out",
                  glog_start[0] - rise_cyc[6], 3);
            check(glog_end[0] - glog_start[0] == 2, "bp_span",
                  glog_end[0] - glog_start[0], 2);
        end else begin
            check(1'b0, "bp_bursts", glog_core.size(), 1);
        end

        // Overlong: 20 beats, last only on beat 20, new address from beat 17
        clear_logs();
        check(bus.err_overlong == 1'b0, "err_pre", bus.err_overlong, 0);
        for (int k = 0; k < 20; k++)
            push_beat(1, rand_beat(), (k < 16) ? 6'h11 : 6'h2A, k == 19);
        drain(300, "drain_overlong");
        check(bus.err_overlong == err_exp, "err_overlong", bus.err_overlong, err_exp);
        if (glog_core.size() == 2 && glog_end.size() == 2) begin
            check(glog_core[0] == 1 && glog_core[1] == 1, "overlong_regrant",
                  {glog_core[0], glog_core[1]}, {32'd1, 32'd1});
            check(glog_start[1] - glog_end[0] == 2, "overlong_bubble",
                  glog_start[1] - glog_end[0], 2);
        end else begin
            check(1'b0, "overlong_bursts", glog_core.size(), 2);
        end

        // Contention: core 5 arrives while core 4 holds the lock
        clear_logs();
        push_burst(4, 4, 6'h07);
        repeat (2) @(negedge clk);
        push_burst(5, 2, 6'h08);
        drain(200, "drain_contend");
        if (glog_core.size() == 2 && glog_end.size() == 2) begin
            check(glog_core[0] == 4 && glog_core[1] == 5, "contend_order",
                  {glog_core[0], glog_core[1]}, {32'd4, 32'd5});
            check(glog_start[1] - glog_end[0] == 2, "contend_bubble",
                  glog_start[1] - glog_end[0], 2);
        end else begin
            check(1'b0, "contend_bursts", glog_core.size(), 2);
        end

        // Reset mid-burst with the output register full and stalled
        clear_logs();
        bp_mode = 2;
        push_burst(2, 8, 6'h3F);
        repeat (6) @(negedge clk);
        check(bus.m_wvalid == 1'b1, "pre_reset_full", bus.m_wvalid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check(bus.m_wvalid == 1'b0, "reset_m_wvalid", bus.m_wvalid, 0);
        check(bus.s_wready == '0, "reset_s_wready", bus.s_wready, 0);
        check(bus.err_overlong == 1'b0, "reset_err", bus.err_overlong, 0);
        flush_model();
        bp_mode = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Round-robin from a fresh pointer, including the 7 -> 0 wrap
        clear_logs();
        for (int r = 0; r < 2; r++) begin
            push_burst(0, 2, 6'h01);
            push_burst(2, 2, 6'h02);
            push_burst(7, 2, 6'h03);
        end
        drain(300, "drain_rr");
        if (glog_core.size() == 6) begin
            for (int i = 0; i < 6; i++)
                check(glog_core[i] == exp_order[i], "rr_order", glog_core[i], exp_order[i]);
        end else begin
            check(1'b0, "rr_bursts", glog_core.size(), 6);
        end

        // Random traffic with valid gaps and random backpressure
        clear_logs();
        gap_pct = 30;
        bp_mode = 1;
        for (int n = 0; n < 40; n++)
            push_burst($urandom_range(NC - 1), $urandom_range(20, 1), SW'($urandom));
        drain(20000, "drain_random");
        gap_pct = 0;
        bp_mode = 0;
        repeat (3) @(negedge clk);
        check(bus.err_overlong == err_exp, "err_random", bus.err_overlong, err_exp);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
